// File: rtl/mem_wb_if.sv
// Bundle of M-stage inputs and WB-facing outputs carried between the memory
// stage, the hazard unit and the mem_wb_stage pipeline register.
interface mem_wb_if;
    logic        stall;
    logic        flush;
    logic [31:0] Instr_in;
    logic [31:0] pc_add_4_in;
    logic [31:0] pc_add_8_in;
    logic [31:0] ALUResult_in;
    logic [31:0] DM_rdata_in;
    logic [4:0]  WriteRegNum_in;
    // Counter preload, used to reach the wrap point without billions of cycles.
    logic        instret_preload_in;
    logic [31:0] instret_preload_val_in;

    logic [31:0] Instr_out;
    logic [31:0] pc_add_4_out;
    logic [31:0] pc_add_8_out;
    logic [31:0] ALUResult_out;
    logic [31:0] DM_data_out;
    logic [4:0]  WriteRegNum_out;
    logic [31:0] instret_count_out;
    logic        adel_out;
    logic [31:0] badvaddr_out;

    modport master (
        output stall, flush, Instr_in, pc_add_4_in, pc_add_8_in, ALUResult_in,
               DM_rdata_in, WriteRegNum_in, instret_preload_in, instret_preload_val_in,
        input  Instr_out, pc_add_4_out, pc_add_8_out, ALUResult_out, DM_data_out,
               WriteRegNum_out, instret_count_out, adel_out, badvaddr_out
    );

    modport slave (
        input  stall, flush, Instr_in, pc_add_4_in, pc_add_8_in, ALUResult_in,
               DM_rdata_in, WriteRegNum_in, instret_preload_in, instret_preload_val_in,
        output Instr_out, pc_add_4_out, pc_add_8_out, ALUResult_out, DM_data_out,
               WriteRegNum_out, instret_count_out, adel_out, badvaddr_out
    );
endinterface

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register with load extraction/extension and retired-instruction counter.
// Optional load address-error detection is enabled by defining MEM_WB_ALIGN_CHECK_EN.
module mem_wb_stage (
    input  logic   clk,
    input  logic   reset_n,
    mem_wb_if.slave bus
);
    localparam logic [5:0] OP_LB  = 6'b100000;
    localparam logic [5:0] OP_LH  = 6'b100001;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_LBU = 6'b100100;
    localparam logic [5:0] OP_LHU = 6'b100101;

    logic [31:0] instr_q, instr_d;
    logic [31:0] pc4_q, pc4_d;
    logic [31:0] pc8_q, pc8_d;
    logic [31:0] alu_q, alu_d;
    logic [31:0] dm_q, dm_d;
    logic [4:0]  wreg_q, wreg_d;
    logic [31:0] cnt_q, cnt_d;
    logic        adel_q, adel_d;
    logic [31:0] bva_q, bva_d;

    logic [5:0]  opcode;
    logic [1:0]  addr_lo;
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;
    logic [31:0] load_data;
    logic        misaligned;

    assign opcode  = bus.Instr_in[31:26];
    assign addr_lo = bus.ALUResult_in[1:0];

    always_comb begin
        sel_byte  = bus.DM_rdata_in[8*addr_lo +: 8];
        sel_half  = addr_lo[1] ? bus.DM_rdata_in[31:16] : bus.DM_rdata_in[15:0];
        load_data = bus.DM_rdata_in;
        case (opcode)
            OP_LB:   load_data = {{24{sel_byte[7]}}, sel_byte};
            OP_LBU:  load_data = {24'h0, sel_byte};
            OP_LH:   load_data = {{16{sel_half[15]}}, sel_half};
            OP_LHU:  load_data = {16'h0, sel_half};
            default: load_data = bus.DM_rdata_in;
        endcase
    end

`ifdef MEM_WB_ALIGN_CHECK_EN
    assign misaligned = ((opcode == OP_LW) && (addr_lo != 2'b00)) ||
                        (((opcode == OP_LH) || (opcode == OP_LHU)) && addr_lo[0]);
`else
    assign misaligned = 1'b0;
`endif

    // Flush beats stall; the counter is never cleared by a bubble, only held.
    always_comb begin
        instr_d = instr_q;
        pc4_d   = pc4_q;
        pc8_d   = pc8_q;
        alu_d   = alu_q;
        dm_d    = dm_q;
        wreg_d  = wreg_q;
        adel_d  = adel_q;
        bva_d   = bva_q;
        cnt_d   = cnt_q;
        if (bus.flush) begin
            instr_d = 32'h0;
            pc4_d   = 32'h0;
            pc8_d   = 32'h0;
            alu_d   = 32'h0;
            dm_d    = 32'h0;
            wreg_d  = 5'd0;
            adel_d  = 1'b0;
            bva_d   = 32'h0;
        end else if (!bus.stall) begin
            instr_d = bus.Instr_in;
            pc4_d   = bus.pc_add_4_in;
            pc8_d   = bus.pc_add_8_in;
            alu_d   = bus.ALUResult_in;
            dm_d    = load_data;
            wreg_d  = misaligned ? 5'd0 : bus.WriteRegNum_in;
            adel_d  = misaligned;
            bva_d   = misaligned ? bus.ALUResult_in : 32'h0;
            if ((bus.Instr_in != 32'h0) && !misaligned)
                cnt_d = cnt_q + 32'd1;
        end
        if (bus.instret_preload_in)
            cnt_d = bus.instret_preload_val_in;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            instr_q <= 32'h0;
            pc4_q   <= 32'h0;
            pc8_q   <= 32'h0;
            alu_q   <= 32'h0;
            dm_q    <= 32'h0;
            wreg_q  <= 5'd0;
            cnt_q   <= 32'h0;
            adel_q  <= 1'b0;
            bva_q   <= 32'h0;
        end else begin
            instr_q <= instr_d;
            pc4_q   <= pc4_d;
            pc8_q   <= pc8_d;
            alu_q   <= alu_d;
            dm_q    <= dm_d;
            wreg_q  <= wreg_d;
            cnt_q   <= cnt_d;
            adel_q  <= adel_d;
            bva_q   <= bva_d;
        end
    end

    assign bus.Instr_out         = instr_q;
    assign bus.pc_add_4_out      = pc4_q;
    assign bus.pc_add_8_out      = pc8_q;
    assign bus.ALUResult_out     = alu_q;
    assign bus.DM_data_out       = dm_q;
    assign bus.WriteRegNum_out   = wreg_q;
    assign bus.instret_count_out = cnt_q;
    assign bus.adel_out          = adel_q;
    assign bus.badvaddr_out      = bva_q;
endmodule
